// File: rtl/mult_share_sched_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int default_timeout(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        logic          found;
        int            cand_i;
        logic [IW-1:0] cand;
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        cand_i = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_i = int'(ptr) + k;
            if (cand_i >= NREQ) cand_i = cand_i - NREQ;
            cand = IW'(cand_i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one sequential multiplier between NREQ requesters,
// with a watchdog that aborts (and resets) a multiplier that never finishes.
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter int N       = 5,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = default_timeout(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_in,
    input  logic [NREQ*N-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*N-1:0]    rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    output logic              mul_start,
    output logic              mul_reset,
    input  logic [2*N-1:0]    mul_out,
    input  logic              mul_finish,
    output logic [1:0]        dbg_state
);

    localparam int IW = clog2(NREQ);
    localparam int WW = clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*N-1:0]  rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [N-1:0]    mul_a_q, mul_a_d;
    logic [N-1:0]    mul_b_q, mul_b_d;
    logic            mul_start_q, mul_start_d;
    logic            abort_q, abort_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        wdog_d      = wdog_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = mul_start_q;
        abort_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d    = arb_grant;
                    mul_a_d  = a_in[int'(arb_idx)*N +: N];
                    mul_b_d  = b_in[int'(arb_idx)*N +: N];
                    cur_d    = arb_idx;
                    rr_ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mul_start_d = 1'b1;
                wdog_d      = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A finish on the last watchdog cycle still counts as success.
                if (mul_finish) begin
                    rsp_data_d         = mul_out;
                    rsp_valid_d[cur_q] = 1'b1;
                    rsp_err_d          = 1'b0;
                    mul_start_d        = 1'b0;
                    state_d            = ST_REL;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    rsp_data_d         = '0;
                    rsp_valid_d[cur_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    mul_start_d        = 1'b0;
                    abort_d            = 1'b1;
                    state_d            = ST_REL;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            wdog_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            wdog_q      <= wdog_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            abort_q     <= abort_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = mul_start_q;
    assign mul_reset = reset | abort_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: behavioural sequential multiplier with configurable latency,
// stuck finish and forced finish; scoreboard queues for grants and responses.
module tb_mult_share_sched;

    localparam int N       = 5;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 2 * N + 4;
    localparam int W       = 13;  // {idx[1:0], err, data[9:0]}

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_in;
    logic [NREQ*N-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*N-1:0]    rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_start;
    logic              mul_reset;
    logic [2*N-1:0]    mul_out;
    logic              mul_finish;
    logic [1:0]        dbg_state;

    mult_share_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_reset  (mul_reset),
        .mul_out    (mul_out),
        .mul_finish (mul_finish),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- multiplier model ----------------
    int         mul_lat;
    int         stub_cnt;
    logic       stuck;
    logic       force_fin;
    logic       fin_q;
    logic [9:0] prod_q;

    always @(posedge clk) begin
        if (mul_reset || !mul_start) begin
            stub_cnt <= 0;
            fin_q    <= 1'b0;
            if (mul_reset) prod_q <= '0;
        end else if (!fin_q && !stuck) begin
            if (stub_cnt == mul_lat - 1) begin
                fin_q  <= 1'b1;
                prod_q <= {5'b0, mul_a} * {5'b0, mul_b};
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    assign mul_out    = prod_q;
    assign mul_finish = fin_q | force_fin;

    // ---------------- scoreboard ----------------
    int             checks;
    int             errors;
    logic [W-1:0]   exp_q[$];
    logic [1:0]     gexp_q[$];
    int             cyc;
    int             last_rsp_cyc;
    logic           job_open;
    logic           gap_check;
    logic           gap_armed;
    logic [1:0]     mon_g;
    logic [W-1:0]   mon_e;
    logic [3:0]     mon_oh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_job(input logic [1:0] idx, input logic err, input logic [9:0] data);
        gexp_q.push_back(idx);
        exp_q.push_back({idx, err, data});
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            job_open = 1'b0;
        end else begin
            if (gnt != 0) begin
                if (gexp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected: got %b expected none", gnt);
                end else begin
                    mon_g  = gexp_q.pop_front();
                    mon_oh = 4'b0001 << mon_g;
                    check("gnt_order", gnt, mon_oh);
                end
                check("gnt_while_busy", job_open, 0);
                job_open = 1'b1;
                if (gap_armed) check("gnt_gap", cyc - last_rsp_cyc, 2);
                gap_armed = 1'b0;
            end
            if (rsp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %b expected none", rsp_valid);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = 4'b0001 << mon_e[12:11];
                    check("rsp_valid", rsp_valid, mon_oh);
                    check("rsp_data", rsp_data, mon_e[9:0]);
                    check("rsp_err", rsp_err, mon_e[10]);
                end
                job_open     = 1'b0;
                last_rsp_cyc = cyc;
                gap_armed    = gap_check;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int i, input logic [4:0] a, input logic [4:0] b);
        a_in[i*N +: N] = a;
        b_in[i*N +: N] = b;
    endtask

    // Raise the requests in mask and drop each one as it is granted.
    task automatic drive_jobs(input logic [3:0] mask);
        int n;
        n   = 0;
        req = mask;
        while (req != 0 && n < 400) begin
            @(negedge clk);
            req = req & ~gnt;
            n++;
        end
        if (req != 0) begin
            check("drive_grant_timeout", req, 0);
            req = '0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st_cnt;
        int mr_cnt;
        int n;
        int g_cnt;

        checks = 0; errors = 0; cyc = 0; last_rsp_cyc = 0;
        job_open = 1'b0; gap_check = 1'b0; gap_armed = 1'b0;
        reset = 1'b1; req = '0; a_in = '0; b_in = '0;
        mul_lat = N; stuck = 1'b0; force_fin = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_mul_reset", mul_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mul_reset_low", mul_reset, 0);

        // 1: single request, latency of grant and start
        set_ops(0, 5'd26, 5'd30);
        push_job(2'd0, 1'b0, 10'd780);
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_state_load", dbg_state, 1);
        check("t1_start_low_in_load", mul_start, 0);
        check("t1_mul_a", mul_a, 26);
        check("t1_mul_b", mul_b, 30);
        req = '0;
        @(negedge clk);
        check("t1_start_high", mul_start, 1);
        check("t1_state_run", dbg_state, 2);
        wait_idle();

        // 2: simultaneous requests 1 and 2, then 3 before 0 shows rr_ptr moved to 3
        set_ops(1, 5'd13, 5'd13);
        set_ops(2, 5'd31, 5'd31);
        push_job(2'd1, 1'b0, 10'd169);
        push_job(2'd2, 1'b0, 10'd961);
        drive_jobs(4'b0110);
        wait_idle();
        set_ops(3, 5'd7, 5'd9);
        push_job(2'd3, 1'b0, 10'd63);
        push_job(2'd0, 1'b0, 10'd780);
        drive_jobs(4'b1001);
        wait_idle();

        // 3: fairness with all requests held, after a reset returns rr_ptr to 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_job(2'd0, 1'b0, 10'd780);
            push_job(2'd1, 1'b0, 10'd169);
            push_job(2'd2, 1'b0, 10'd961);
            push_job(2'd3, 1'b0, 10'd63);
        end
        gap_check = 1'b1;
        req   = 4'b1111;
        g_cnt = 0;
        n     = 0;
        while (g_cnt < 8 && n < 600) begin
            @(negedge clk);
            if (gnt != 0) g_cnt++;
            n++;
        end
        check("t3_grant_count", g_cnt, 8);
        req = '0;
        gap_check = 1'b0;
        wait_idle();

        // 4: stuck multiplier -> watchdog abort, then a clean job
        stuck = 1'b1;
        push_job(2'd0, 1'b1, 10'd0);
        req = 4'b0001;
        st_cnt = 0; mr_cnt = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            req = req & ~gnt;
            if (mul_start) st_cnt++;
            if (mul_reset) mr_cnt++;
            n++;
            if (rsp_valid != 0) break;
        end
        @(negedge clk);
        if (mul_reset) mr_cnt++;
        check("t4_run_cycles", st_cnt, TIMEOUT);
        check("t4_mul_reset_pulse", mr_cnt, 1);
        wait_idle();
        stuck = 1'b0;
        push_job(2'd1, 1'b0, 10'd169);
        drive_jobs(4'b0010);
        wait_idle();
        check("t4_err_cleared", rsp_err, 0);

        // 5: reset three cycles into RUN drops the job
        mul_lat = 10;
        gexp_q.push_back(2'd2);
        req = 4'b0100;
        n = 0;
        while (!mul_start && n < 50) begin
            @(negedge clk);
            req = req & ~gnt;
            n++;
        end
        check("t5_reached_run", mul_start, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_gnt", gnt, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_rsp_data", rsp_data, 0);
        check("t5_busy", busy, 0);
        check("t5_mul_start", mul_start, 0);
        check("t5_mul_ab", {mul_a, mul_b}, 0);
        check("t5_state", dbg_state, 0);
        check("t5_mul_reset", mul_reset, 1);
        reset = 1'b0;
        mul_lat = N;
        set_ops(3, 5'd0, 5'd17);
        push_job(2'd3, 1'b0, 10'd0);
        drive_jobs(4'b1000);
        wait_idle();

        // 6: finish on the last watchdog cycle wins; one cycle later is an abort
        mul_lat = TIMEOUT - 1;
        push_job(2'd0, 1'b0, 10'd780);
        req = 4'b0001;
        mr_cnt = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            req = req & ~gnt;
            if (mul_reset) mr_cnt++;
            n++;
            if (rsp_valid != 0) break;
        end
        @(negedge clk);
        if (mul_reset) mr_cnt++;
        check("t6_no_abort", mr_cnt, 0);
        wait_idle();
        mul_lat = TIMEOUT;
        push_job(2'd1, 1'b1, 10'd0);
        drive_jobs(4'b0010);
        wait_idle();
        mul_lat = N;

        // Spurious finish while idle must be ignored
        force_fin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_idle_busy", busy, 0);
        end
        force_fin = 1'b0;
        repeat (4) @(negedge clk);

        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_gexp_q_empty", gexp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
